// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO for the EX stage.
// Optional abort input enabled by defining MDU_CANCEL_EN.
module mdu_hilo #(
  parameter int MUL_LATENCY = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic [63:0] prod_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] dvs_reg;
  logic [31:0] dz_hi_reg;
  logic [31:0] dz_lo_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        dz_reg;

  logic        kill;
  logic        is_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] prod_next;
  logic [32:0] shift_rem;
  logic        ge;
  logic [31:0] sub_rem;

`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  // MULT and DIV are the even opcodes; MULTU/DIVU the odd ones.
  assign is_signed = ~op[0];
  assign mag_a     = (is_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
  assign mag_b     = (is_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
  assign prod_next = is_signed ? ({{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b})
                               : ({32'd0, src_a} * {32'd0, src_b});

  // One restoring step: the partial remainder is always below the divisor,
  // so after a successful subtract the result fits in 32 bits.
  assign shift_rem = {rem_reg, quo_reg[31]};
  assign ge        = shift_rem >= {1'b0, dvs_reg};
  assign sub_rem   = shift_rem[31:0] - dvs_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      busy      <= 1'b0;
      cnt_reg   <= 6'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else if (kill) begin
      state_reg <= S_IDLE;
      busy      <= 1'b0;
      cnt_reg   <= 6'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1: begin
                prod_reg  <= prod_next;
                cnt_reg   <= 6'(MUL_LATENCY);
                state_reg <= S_MUL;
                busy      <= 1'b1;
              end
              3'd2, 3'd3: begin
                rem_reg   <= 32'd0;
                quo_reg   <= mag_a;
                dvs_reg   <= mag_b;
                q_neg_reg <= is_signed & (src_a[31] ^ src_b[31]);
                r_neg_reg <= is_signed & src_a[31];
                dz_reg    <= (src_b == 32'd0);
                dz_hi_reg <= src_a;
                dz_lo_reg <= (is_signed && src_a[31]) ? 32'd1 : 32'hFFFF_FFFF;
                cnt_reg   <= 6'd33;
                state_reg <= S_DIV;
                busy      <= 1'b1;
              end
              3'd4:    hi <= src_a;
              3'd5:    lo <= src_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          cnt_reg <= cnt_reg - 6'd1;
          if (cnt_reg == 6'd1) begin
            hi        <= prod_reg[63:32];
            lo        <= prod_reg[31:0];
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        S_DIV: begin
          cnt_reg <= cnt_reg - 6'd1;
          if (cnt_reg == 6'd1) begin
            if (dz_reg) begin
              hi <= dz_hi_reg;
              lo <= dz_lo_reg;
            end else begin
              hi <= r_neg_reg ? (32'd0 - rem_reg) : rem_reg;
              lo <= q_neg_reg ? (32'd0 - quo_reg) : quo_reg;
            end
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            rem_reg <= ge ? sub_rem : shift_rem[31:0];
            quo_reg <= {quo_reg[30:0], ge};
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with HI/LO registers in the EX stage.
- Consumes the forwarded rs/rt operand values produced by the operand forwarding controllers.
- Drives `busy` to the hazard/stall logic, so mfhi/mflo and new mult/div ops stall until the result is committed.
- Drives `hi`/`lo` back into the forwarding network as the mfhi/mflo source.

Parameters:
- MUL_LATENCY, 5, cycles from accepted mult/multu to HI/LO commit; legal range 1..15.
- DIV_LATENCY, 33, fixed for div/divu: 32 restoring iterations plus 1 sign-fixup cycle. Not user-settable; listed for the bench.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  accept `op` with `src_a`/`src_b` this cycle.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 are no-op.
- src_a  in  32  forwarded rs value.
- src_b  in  32  forwarded rt value.
- cancel  in  1  abort in-flight op; present only with MDU_CANCEL_EN.
- busy  out  1  operation in flight; HI/LO not yet final.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (sampled at a clk edge with reset=0):
  - hi=0, lo=0, busy=0, internal counter=0, state=IDLE.
  - Reset mid-operation discards the op; no HI/LO update.
- States:
  - IDLE: busy=0.
  - MUL: counter loaded with MUL_LATENCY.
  - DIV: counter loaded with 33.
  - busy = (state != IDLE), registered.
- Accept: at an edge with start=1, state=IDLE and op in 0..3:
  - latch the operands;
  - load the counter;
  - enter MUL or DIV.
  - busy is 1 from the following cycle.
- start while busy: ignored, no effect. The hazard unit guarantees this does not happen; the bench checks it is harmless.
- MTHI/MTLO (op 4/5) with start=1 in IDLE:
  - hi (resp. lo) takes src_a at that edge;
  - busy stays 0.
- MUL/MULTU:
  - {hi,lo} = 64-bit product, signed or unsigned; may be computed at accept and delayed.
  - The counter decrements each edge. At the edge where it reaches 0, {hi,lo} are written and state returns to IDLE.
  - busy is high for exactly MUL_LATENCY cycles.
- DIV/DIVU:
  - Radix-2 restoring division on magnitudes (signed ops take absolute values at accept).
  - One quotient bit per edge for 32 edges; the 33rd edge applies signs and commits:
    - quotient sign = sign(a) XOR sign(b);
    - remainder sign = sign(a);
    - lo = quotient, hi = remainder.
  - busy is high for 33 cycles.
- During busy, hi/lo hold their pre-operation values. They change only on the commit edge.
- Divide by zero (defined, no trap):
  - DIVU: lo=0xFFFFFFFF, hi=src_a.
  - DIV: lo = (src_a<0) ? 0x00000001 : 0xFFFFFFFF, hi=src_a.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Back-to-back: start may be accepted in the same cycle busy falls (state IDLE at that edge). No dead cycle is required.
- The commit edge and reset=0 at the same edge: reset wins.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - The `cancel` port exists.
  - cancel=1 at any edge while busy: state goes to IDLE, busy=0 next cycle, hi/lo unchanged (the op never commits).
  - cancel=1 together with start at the accept edge: the op is not accepted.
  - cancel=1 on the commit edge: the commit is suppressed.
  - cancel while IDLE has no effect; MTHI/MTLO are also suppressed if cancel=1 at their edge.
- Not defined:
  - No `cancel` port.
  - Every accepted op runs to completion unless reset.

Test Plan:
- Reset then MULTU a=0xFFFFFFFF b=0xFFFFFFFF, MUL_LATENCY=5 -> busy high 5 cycles; on fall hi=0xFFFFFFFE, lo=0x00000001; hi/lo stay 0 while busy.
- MULT a=0xFFFFFFFE(-2) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA after 5 cycles.
- DIV a=-7 (0xFFFFFFF9) b=2 -> busy 33 cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
- Edge cases:
  - DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> busy never asserts; hi/lo updated one edge after each start. Then start DIVU 10/3 in the cycle busy falls after a prior MULT -> accepted; result lo=3, hi=1.
- Cancel and reset (MDU_CANCEL_EN defined):
  - DIVU 10/3, cancel at cycle 10 -> busy 0 next cycle; hi/lo keep prior values.
  - Repeat with reset=0 at cycle 20 of a DIV -> hi=lo=0, busy=0.
